// File: rtl/tile_pkg.sv
// Shared constants, error codes and FSM states for the tile-order reader.
package tile_pkg;
  localparam int ID_W       = 4;
  localparam int N_EDGE     = 24;
  localparam int N_CENTER   = 12;
  localparam int NUM_PIC    = 12;
  localparam int EXP_EDGE   = 2;
  localparam int EXP_CENTER = 1;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_BAD_ID     = 2'd1;
  localparam logic [1:0] ERR_EDGE_CNT   = 2'd2;
  localparam logic [1:0] ERR_CENTER_CNT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CHK_EDGE   = 2'd1,
    ST_CHK_CENTER = 2'd2,
    ST_VERDICT    = 2'd3
  } state_e;
endpackage

// File: rtl/tile_histogram.sv
// Bank of NUM_PIC saturating 2-bit occurrence counters; all_match is high
// when every picture has been seen exactly EXPECTED times.
module tile_histogram
  import tile_pkg::*;
#(
  parameter int EXPECTED = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  input  logic [ID_W-1:0] id,
  output logic            all_match
);

  logic [NUM_PIC-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PIC; gi++) begin : g_cnt
      logic [1:0] cnt_q;
      logic [1:0] cnt_d;

      // Clear on request, otherwise count hits on this picture, saturating at 3
      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = 2'd0;
        end else if (inc && (id == ID_W'(gi)) && (cnt_q != 2'd3)) begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      // Counter register
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= 2'd0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign match[gi] = (cnt_q == 2'(EXPECTED));
    end
  endgenerate

  assign all_match = &match;

endmodule

// File: rtl/tile_order_reader.sv
// Captures packed edge/center tile orders, validates them one slot per cycle
// against the expected picture histograms, then serves slot IDs via a
// registered read port.
module tile_order_reader
  import tile_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [N_EDGE*ID_W-1:0]   edge_order_i,
  input  logic [N_CENTER*ID_W-1:0] center_order_i,
  output logic                     busy,
  output logic                     done,
  output logic                     order_ok,
  output logic [1:0]               err_code,
  input  logic                     rd_en,
  input  logic                     rd_sel,
  input  logic [4:0]               rd_addr,
  output logic                     rd_valid,
  output logic [ID_W-1:0]          rd_data
);

  state_e state_q, state_d;

  logic [N_EDGE*ID_W-1:0]   edge_tbl_q, edge_tbl_d;
  logic [N_CENTER*ID_W-1:0] center_tbl_q, center_tbl_d;
  logic [4:0]               idx_q, idx_d;
  logic                     bad_id_q, bad_id_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     order_ok_q, order_ok_d;
  logic [1:0]               err_q, err_d;
  logic                     rd_valid_q, rd_valid_d;
  logic [ID_W-1:0]          rd_data_q, rd_data_d;

  logic [ID_W-1:0] cur_id;
  logic            id_legal;
  logic            hist_clr;
  logic            edge_inc, center_inc;
  logic            edge_match, center_match;

  // The slot under inspection comes from whichever table is being walked
  assign cur_id   = (state_q == ST_CHK_CENTER) ? center_tbl_q[idx_q*ID_W +: ID_W]
                                               : edge_tbl_q[idx_q*ID_W +: ID_W];
  assign id_legal = (cur_id < ID_W'(NUM_PIC));
  assign hist_clr = (state_q == ST_IDLE) && load;
  // Illegal IDs never touch the histograms; they only raise the sticky flag
  assign edge_inc   = (state_q == ST_CHK_EDGE) && id_legal;
  assign center_inc = (state_q == ST_CHK_CENTER) && id_legal;

  tile_histogram #(.EXPECTED(EXP_EDGE)) u_edge_hist (
    .clk       (clk),
    .rst       (rst),
    .clr       (hist_clr),
    .inc       (edge_inc),
    .id        (cur_id),
    .all_match (edge_match)
  );

  tile_histogram #(.EXPECTED(EXP_CENTER)) u_center_hist (
    .clk       (clk),
    .rst       (rst),
    .clr       (hist_clr),
    .inc       (center_inc),
    .id        (cur_id),
    .all_match (center_match)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: walk all edge slots, then all center slots, then decide
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (load) state_d = ST_CHK_EDGE;
      ST_CHK_EDGE:   if (idx_q == 5'(N_EDGE - 1)) state_d = ST_CHK_CENTER;
      ST_CHK_CENTER: if (idx_q == 5'(N_CENTER - 1)) state_d = ST_VERDICT;
      ST_VERDICT:    state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath next values; the read port works in every state
  always_comb begin
    edge_tbl_d   = edge_tbl_q;
    center_tbl_d = center_tbl_q;
    idx_d        = idx_q;
    bad_id_d     = bad_id_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    order_ok_d   = order_ok_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          edge_tbl_d   = edge_order_i;
          center_tbl_d = center_order_i;
          idx_d        = 5'd0;
          bad_id_d     = 1'b0;
          busy_d       = 1'b1;
          order_ok_d   = 1'b0;
          err_d        = ERR_NONE;
        end
      end
      ST_CHK_EDGE: begin
        idx_d    = (idx_q == 5'(N_EDGE - 1)) ? 5'd0 : idx_q + 5'd1;
        bad_id_d = bad_id_q | ~id_legal;
      end
      ST_CHK_CENTER: begin
        idx_d    = (idx_q == 5'(N_CENTER - 1)) ? 5'd0 : idx_q + 5'd1;
        bad_id_d = bad_id_q | ~id_legal;
      end
      ST_VERDICT: begin
        // Lowest applicable code wins
        if (bad_id_q)          err_d = ERR_BAD_ID;
        else if (!edge_match)  err_d = ERR_EDGE_CNT;
        else if (!center_match) err_d = ERR_CENTER_CNT;
        else                   err_d = ERR_NONE;
        order_ok_d = (err_d == ERR_NONE);
        done_d     = 1'b1;
        busy_d     = 1'b0;
      end
      default: ;
    endcase

    // Reads see the pre-edge tables and order_ok, so a same-edge load
    // still returns the old contents
    rd_valid_d = rd_en;
    rd_data_d  = '0;
    if (rd_en && order_ok_q) begin
      if (!rd_sel && (rd_addr < 5'(N_EDGE))) begin
        rd_data_d = edge_tbl_q[rd_addr*ID_W +: ID_W];
      end else if (rd_sel && (rd_addr < 5'(N_CENTER))) begin
        rd_data_d = center_tbl_q[rd_addr*ID_W +: ID_W];
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_tbl_q   <= '0;
      center_tbl_q <= '0;
      idx_q        <= 5'd0;
      bad_id_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      order_ok_q   <= 1'b0;
      err_q        <= ERR_NONE;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      edge_tbl_q   <= edge_tbl_d;
      center_tbl_q <= center_tbl_d;
      idx_q        <= idx_d;
      bad_id_q     <= bad_id_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      order_ok_q   <= order_ok_d;
      err_q        <= err_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign order_ok = order_ok_q;
  assign err_code = err_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
